// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit:
// state names, opcodes, immediate formats, ALU operations and datapath selects.
package ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
      EXECI, ALUWB, BRANCH, JAL, JALR, LUI, TRAP
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] IMM_I  = 3'b000;
   localparam logic [2:0] IMM_S  = 3'b001;
   localparam logic [2:0] IMM_B  = 3'b010;
   localparam logic [2:0] IMM_U  = 3'b011;
   localparam logic [2:0] IMM_J  = 3'b100;
   localparam logic [2:0] IMM_SH = 3'b101;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLL  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   // ALU operand and result mux selects
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_REG   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;
   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   function automatic logic [2:0] imm_sel(input logic [6:0] opcode, input logic [2:0] funct3);
      logic [2:0] sel;
      sel = IMM_I;
      case (opcode)
         OP_I:             sel = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SH : IMM_I;
         OP_STORE:         sel = IMM_S;
         OP_BRANCH:        sel = IMM_B;
         OP_LUI, OP_AUIPC: sel = IMM_U;
         OP_JAL:           sel = IMM_J;
         default:          sel = IMM_I;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation decode from opcode, funct3 and funct7 bit 5.
module alu_decoder
   import ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output logic [3:0] alu_ctrl
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      if (opcode == OP_BRANCH) begin
         alu_ctrl = ALU_SUB;
      end else if (opcode == OP_R || opcode == OP_I) begin
         case (funct3)
            // ADDI never subtracts; bit 30 there belongs to the immediate
            3'b000:  alu_ctrl = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_ctrl = ALU_SLL;
            3'b010:  alu_ctrl = ALU_SLT;
            3'b011:  alu_ctrl = ALU_SLTU;
            3'b100:  alu_ctrl = ALU_XOR;
            3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_ctrl = ALU_OR;
            default: alu_ctrl = ALU_AND;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM with memory-wait timeout and sticky trap.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        addr_src,
   output logic        pc_write,
   output logic        ir_write,
   output logic        reg_write,
   output logic [2:0]  imm_src,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  result_src,
   output logic [3:0]  alu_ctrl,
   output logic        trap
);

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

   state_t     state, state_next;
   logic [7:0] wait_cnt;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [3:0] dec_alu;
   logic       timed_out;
   logic       unused_instr;

   assign opcode       = instr[6:0];
   assign funct3       = instr[14:12];
   assign timed_out    = (wait_cnt == LAST_WAIT);
   assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

   alu_decoder u_alu_dec (
      .opcode   (opcode),
      .funct3   (funct3),
      .funct7_5 (instr[30]),
      .alu_ctrl (dec_alu)
   );

   // Any state change clears the counter, so every memory state starts fresh
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= FETCH;
         wait_cnt <= '0;
      end else begin
         state <= state_next;
         if (state_next != state)
            wait_cnt <= '0;
         else if (mem_req && !mem_ready)
            wait_cnt <= wait_cnt + 8'd1;
      end
   end

   always_comb begin
      state_next = state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_src   = 1'b0;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      trap       = 1'b0;
      imm_src    = IMM_I;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_REG;
      result_src = RES_ALUOUT;
      alu_ctrl   = ALU_ADD;
      // Outputs are forced quiet while reset is held, independent of the clock
      if (!rst) begin
         if (state != FETCH) imm_src = imm_sel(opcode, funct3);
         case (state)
            FETCH: begin
               mem_req    = 1'b1;
               alu_src_b  = SRCB_FOUR;
               result_src = RES_ALU;
               if (mem_ready) begin
                  ir_write   = 1'b1;
                  pc_write   = 1'b1;
                  state_next = DECODE;
               end else if (timed_out) begin
                  state_next = TRAP;
               end
            end
            DECODE: begin
               alu_src_a = SRCA_OLDPC;
               alu_src_b = SRCB_IMM;
               case (opcode)
                  OP_LOAD, OP_STORE: state_next = MEMADR;
                  OP_R:              state_next = EXECR;
                  OP_I:              state_next = EXECI;
                  OP_BRANCH:         state_next = BRANCH;
                  OP_JAL:            state_next = JAL;
                  OP_JALR:           state_next = JALR;
                  OP_LUI, OP_AUIPC:  state_next = LUI;
                  default:           state_next = TRAP;
               endcase
            end
            MEMADR: begin
               alu_src_a  = SRCA_REG;
               alu_src_b  = SRCB_IMM;
               state_next = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
               mem_req  = 1'b1;
               addr_src = 1'b1;
               if (mem_ready)      state_next = MEMWB;
               else if (timed_out) state_next = TRAP;
            end
            MEMWB: begin
               reg_write  = 1'b1;
               result_src = RES_MEM;
               state_next = FETCH;
            end
            MEMWRITE: begin
               mem_req  = 1'b1;
               mem_we   = 1'b1;
               addr_src = 1'b1;
               if (mem_ready)      state_next = FETCH;
               else if (timed_out) state_next = TRAP;
            end
            EXECR: begin
               alu_src_a  = SRCA_REG;
               alu_ctrl   = dec_alu;
               state_next = ALUWB;
            end
            EXECI: begin
               alu_src_a  = SRCA_REG;
               alu_src_b  = SRCB_IMM;
               alu_ctrl   = dec_alu;
               state_next = ALUWB;
            end
            ALUWB: begin
               reg_write  = 1'b1;
               state_next = FETCH;
            end
            BRANCH: begin
               alu_src_a = SRCA_REG;
               alu_ctrl  = dec_alu;
               // Target was precomputed into ALUOut during DECODE
               if (funct3 == 3'b000) begin
                  pc_write   = zero;
                  state_next = FETCH;
               end else if (funct3 == 3'b001) begin
                  pc_write   = !zero;
                  state_next = FETCH;
               end else begin
                  state_next = TRAP;
               end
            end
            JAL: begin
               alu_src_a  = SRCA_OLDPC;
               alu_src_b  = SRCB_FOUR;
               pc_write   = 1'b1;
               reg_write  = 1'b1;
               state_next = FETCH;
            end
            JALR: begin
               alu_src_a  = SRCA_REG;
               alu_src_b  = SRCB_IMM;
               result_src = RES_ALU;
               pc_write   = 1'b1;
               reg_write  = 1'b1;
               state_next = FETCH;
            end
            LUI: begin
               alu_src_a  = (opcode == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
               alu_src_b  = SRCB_IMM;
               result_src = RES_ALU;
               reg_write  = 1'b1;
               state_next = FETCH;
            end
            TRAP: begin
               trap = 1'b1;
            end
            default: state_next = TRAP;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: scripted per-cycle traces from an instruction-level model.
module tb_multicycle_ctrl;
   import ctrl_pkg::*;

   localparam int T = 4;

   logic        clk, rst, zero, mem_ready;
   logic [31:0] instr;
   logic        mem_req, mem_we, addr_src, pc_write, ir_write, reg_write, trap;
   logic [2:0]  imm_src;
   logic [1:0]  alu_src_a, alu_src_b, result_src;
   logic [3:0]  alu_ctrl;
   logic [6:0]  obs_ctl;

   multicycle_ctrl #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .addr_src(addr_src), .pc_write(pc_write),
      .ir_write(ir_write), .reg_write(reg_write), .imm_src(imm_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
      .alu_ctrl(alu_ctrl), .trap(trap)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign obs_ctl = {mem_req, mem_we, addr_src, pc_write, ir_write, reg_write, trap};

   localparam logic [6:0] MR = 7'b1000000, WE = 7'b0100000, AS = 7'b0010000,
                          PW = 7'b0001000, IW = 7'b0000100, RW = 7'b0000010,
                          TR = 7'b0000001, NONE = 7'b0000000;
   localparam logic [3:0] A0 = 4'b0000;
   localparam logic [2:0] I0 = 3'b000;

   typedef struct {
      logic       mr;
      logic       z;
      logic [6:0] ctl;
      bit         ci;
      logic [2:0] imm;
      bit         ca;
      logic [3:0] alu;
   } cyc_t;

   cyc_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic void push(logic mr, logic z, logic [6:0] c, bit ci, logic [2:0] im,
                                bit ca, logic [3:0] al);
      cyc_t e;
      e.mr = mr; e.z = z; e.ctl = c; e.ci = ci; e.imm = im; e.ca = ca; e.alu = al;
      exp_q.push_back(e);
   endfunction

   function automatic logic [2:0] imm_of(logic [31:0] in);
      case (in[6:0])
         7'b0010011:             return (in[14:12] == 3'b001 || in[14:12] == 3'b101) ? 3'b101 : 3'b000;
         7'b0100011:             return 3'b001;
         7'b1100011:             return 3'b010;
         7'b0110111, 7'b0010111: return 3'b011;
         7'b1101111:             return 3'b100;
         default:                return 3'b000;
      endcase
   endfunction

   function automatic logic [3:0] alu_of(logic [31:0] in);
      bit rtype;
      rtype = (in[6:0] == 7'b0110011);
      case (in[14:12])
         3'd0:    return (rtype && in[30]) ? ALU_SUB : ALU_ADD;
         3'd1:    return ALU_SLL;
         3'd2:    return ALU_SLT;
         3'd3:    return ALU_SLTU;
         3'd4:    return ALU_XOR;
         3'd5:    return in[30] ? ALU_SRA : ALU_SRL;
         3'd6:    return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic void trap_tail(bit ci, logic [2:0] im);
      for (int i = 0; i < 3; i++) push(rb(), rb(), TR, ci, im, 1'b0, A0);
   endfunction

   // One memory access: lat idle cycles before ready; returns 1 on timeout
   function automatic bit access(int lat, logic [6:0] c, logic [6:0] done, bit ci, logic [2:0] im);
      int w;
      w = (lat < T) ? lat : T;
      for (int i = 0; i < w; i++) push(1'b0, rb(), c, ci, im, 1'b0, A0);
      if (lat < T) begin
         push(1'b1, rb(), done, ci, im, 1'b0, A0);
         return 1'b0;
      end
      return 1'b1;
   endfunction

   // Expected cycle trace of one instruction; returns 1 if it ends in TRAP
   function automatic bit model(logic [31:0] in, logic zv, int lf, int lm);
      logic [2:0] f3, im;
      f3 = in[14:12];
      im = imm_of(in);
      if (access(lf, MR, MR | PW | IW, 1'b0, I0)) begin
         trap_tail(1'b0, I0);
         return 1'b1;
      end
      push(rb(), rb(), NONE, 1'b1, im, 1'b0, A0);
      case (in[6:0])
         7'b0000011: begin
            push(rb(), rb(), NONE, 1'b1, im, 1'b0, A0);
            if (access(lm, MR | AS, MR | AS, 1'b1, im)) begin
               trap_tail(1'b1, im);
               return 1'b1;
            end
            push(rb(), rb(), RW, 1'b1, im, 1'b0, A0);
         end
         7'b0100011: begin
            push(rb(), rb(), NONE, 1'b1, im, 1'b0, A0);
            if (access(lm, MR | WE | AS, MR | WE | AS, 1'b1, im)) begin
               trap_tail(1'b1, im);
               return 1'b1;
            end
         end
         7'b0110011, 7'b0010011: begin
            push(rb(), rb(), NONE, 1'b1, im, 1'b1, alu_of(in));
            push(rb(), rb(), RW, 1'b1, im, 1'b0, A0);
         end
         7'b1100011: begin
            if (f3 > 3'd1) begin
               push(rb(), zv, NONE, 1'b1, im, 1'b1, ALU_SUB);
               trap_tail(1'b1, im);
               return 1'b1;
            end
            push(rb(), zv, ((f3 == 3'd0) == zv) ? PW : NONE, 1'b1, im, 1'b1, ALU_SUB);
         end
         7'b1101111, 7'b1100111: push(rb(), rb(), PW | RW, 1'b1, im, 1'b0, A0);
         7'b0110111, 7'b0010111: push(rb(), rb(), RW, 1'b1, im, 1'b0, A0);
         default: begin
            trap_tail(1'b1, im);
            return 1'b1;
         end
      endcase
      return 1'b0;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; mem_ready = 1'b1; zero = 1'b1; instr = 32'h00500093;
      @(negedge clk); #2;
      n_tests++;
      if ({obs_ctl, imm_src, alu_src_a, alu_src_b, result_src, alu_ctrl} !== 20'b0) begin
         n_fail++;
         $display("FAIL reset_outputs got %b want 0",
                  {obs_ctl, imm_src, alu_src_a, alu_src_b, result_src, alu_ctrl});
      end
      @(negedge clk);
      rst = 1'b0; mem_ready = 1'b0; #2;
      n_tests++;
      if (obs_ctl !== MR) begin
         n_fail++; $display("FAIL reset_release_fetch got %b want %b", obs_ctl, MR);
      end
      mem_ready = 1'b1; #1;
      n_tests++;
      if (obs_ctl !== (MR | PW | IW)) begin
         n_fail++; $display("FAIL fetch_ready got %b want %b", obs_ctl, MR | PW | IW);
      end
      @(negedge clk);
      rst = 1'b1; #1; rst = 1'b0; mem_ready = 1'b0; #1;
      n_tests++;
      if (obs_ctl !== MR) begin
         n_fail++; $display("FAIL async_reset_pulse got %b want %b", obs_ctl, MR);
      end
      @(negedge clk);
      do_reset();
   endtask

   task automatic test_directed();
      logic [31:0] d_in [10];
      logic        d_z  [10];
      int          d_lf [10];
      int          d_lm [10];
      cyc_t        c;
      bit          tr;
      // ADDI, SW, BEQ z=1, BEQ z=0, BNE, SRAI, SUB, JAL, LW, illegal
      d_in = '{32'h00500093, 32'h00112223, 32'h00208463, 32'h00208463, 32'h00209463,
               32'h4010D093, 32'h402080B3, 32'h008000EF, 32'h00412183, 32'h00000000};
      d_z  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      d_lf = '{1, 0, 3, 2, 0, 1, 0, 3, 2, 1};
      d_lm = '{0, 3, 0, 0, 0, 0, 0, 0, 3, 0};
      for (int i = 0; i < 10; i++) begin
         instr = d_in[i];
         tr = model(d_in[i], d_z[i], d_lf[i], d_lm[i]);
         for (int k = 0; exp_q.size() > 0; k++) begin
            c = exp_q.pop_front();
            mem_ready = c.mr; zero = c.z; #2;
            n_tests++;
            if (obs_ctl !== c.ctl) begin
               n_fail++; $display("FAIL directed%0d step%0d ctl got %b want %b", i, k, obs_ctl, c.ctl);
            end
            if (c.ci) begin
               n_tests++;
               if (imm_src !== c.imm) begin
                  n_fail++; $display("FAIL directed%0d step%0d imm_src got %b want %b", i, k, imm_src, c.imm);
               end
            end
            if (c.ca) begin
               n_tests++;
               if (alu_ctrl !== c.alu) begin
                  n_fail++; $display("FAIL directed%0d step%0d alu_ctrl got %b want %b", i, k, alu_ctrl, c.alu);
               end
            end
            @(negedge clk);
         end
         if (tr) do_reset();
      end
   endtask

   task automatic test_timeout();
      logic [31:0] t_in [2];
      int          t_lf [2];
      cyc_t        c;
      bit          tr;
      t_in = '{32'h00412183, 32'h00500093};
      t_lf = '{0, 9};
      for (int i = 0; i < 2; i++) begin
         instr = t_in[i];
         tr = model(t_in[i], 1'b0, t_lf[i], 50);
         n_tests++;
         if (tr !== 1'b1) begin
            n_fail++; $display("FAIL timeout%0d model_trap got %b want 1", i, tr);
         end
         for (int k = 0; exp_q.size() > 0; k++) begin
            c = exp_q.pop_front();
            mem_ready = c.mr; zero = c.z; #2;
            n_tests++;
            if (obs_ctl !== c.ctl) begin
               n_fail++; $display("FAIL timeout%0d step%0d ctl got %b want %b", i, k, obs_ctl, c.ctl);
            end
            if (c.ci) begin
               n_tests++;
               if (imm_src !== c.imm) begin
                  n_fail++; $display("FAIL timeout%0d step%0d imm_src got %b want %b", i, k, imm_src, c.imm);
               end
            end
            @(negedge clk);
         end
         do_reset();
         mem_ready = 1'b0; #2;
         n_tests++;
         if ({trap, mem_req} !== 2'b01) begin
            n_fail++; $display("FAIL timeout%0d after_reset trap,mem_req got %b want 01", i, {trap, mem_req});
         end
         @(negedge clk);
         do_reset();
      end
   endtask

   task automatic test_reset_mid();
      cyc_t c;
      bit   tr;
      instr = 32'h00412183;
      tr = model(instr, 1'b0, 0, 50);
      // fetch, decode, memadr, then two idle MEMREAD cycles
      for (int k = 0; k < 5 && exp_q.size() > 0; k++) begin
         c = exp_q.pop_front();
         mem_ready = c.mr; zero = c.z; #2;
         n_tests++;
         if (obs_ctl !== c.ctl) begin
            n_fail++; $display("FAIL reset_mid step%0d ctl got %b want %b", k, obs_ctl, c.ctl);
         end
         @(negedge clk);
      end
      exp_q.delete();
      rst = 1'b1; #2;
      n_tests++;
      if (obs_ctl !== NONE) begin
         n_fail++; $display("FAIL reset_mid abandon got %b want %b", obs_ctl, NONE);
      end
      @(negedge clk);
      rst = 1'b0; mem_ready = 1'b0; #2;
      n_tests++;
      if (obs_ctl !== MR) begin
         n_fail++; $display("FAIL reset_mid refetch got %b want %b", obs_ctl, MR);
      end
      @(negedge clk);
      do_reset();
   endtask

   task automatic test_random();
      logic [6:0] ops [10];
      logic [31:0] in;
      cyc_t c;
      bit   tr;
      int   lf, lm;
      ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0000000};
      for (int i = 0; i < 40; i++) begin
         in = $urandom;
         in[6:0] = ops[$urandom_range(0, 9)];
         if (i % 10 == 9) in[6:0] = 7'($urandom);
         if (in[6:0] == 7'b1100011 && $urandom_range(0, 3) != 0) in[14:12] = {2'b00, rb()};
         lf = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
         lm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
         instr = in;
         tr = model(in, rb(), lf, lm);
         for (int k = 0; exp_q.size() > 0; k++) begin
            c = exp_q.pop_front();
            mem_ready = c.mr; zero = c.z; #2;
            n_tests++;
            if (obs_ctl !== c.ctl) begin
               n_fail++; $display("FAIL rand%0d instr %h step%0d ctl got %b want %b", i, in, k, obs_ctl, c.ctl);
            end
            if (c.ci) begin
               n_tests++;
               if (imm_src !== c.imm) begin
                  n_fail++; $display("FAIL rand%0d instr %h step%0d imm_src got %b want %b", i, in, k, imm_src, c.imm);
               end
            end
            if (c.ca) begin
               n_tests++;
               if (alu_ctrl !== c.alu) begin
                  n_fail++; $display("FAIL rand%0d instr %h step%0d alu_ctrl got %b want %b", i, in, k, alu_ctrl, c.alu);
               end
            end
            @(negedge clk);
         end
         if (tr) do_reset();
      end
   endtask

   initial begin
      rst = 1'b1; zero = 1'b0; mem_ready = 1'b0; instr = '0;
      test_reset();
      test_directed();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired tests=%0d", n_tests);
      $fatal(1);
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles the block waits for mem_ready before trapping (range 1..255).
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 instr  input  32  instruction register contents; valid from DECODE onward.
REQ-005 zero  input  1  ALU zero flag, sampled in BRANCH.
REQ-006 mem_ready  input  1  memory completion strobe for the current mem_req.
REQ-007 mem_req  output  1  memory access request, held until mem_ready or timeout.
REQ-008 mem_we  output  1  write qualifier for mem_req.
REQ-009 addr_src  output  1  0 = PC address, 1 = ALU result address.
REQ-010 pc_write, ir_write, reg_write  output  1 each  single-cycle write enables.
REQ-011 imm_src  output  3  immediate format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101 shift-immediate.
REQ-012 alu_src_a, alu_src_b, result_src  output  2 each  datapath mux selects.
REQ-013 alu_ctrl  output  4  ALU operation code.
REQ-014 trap  output  1  sticky illegal-instruction/timeout flag.

Function
REQ-015 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LUI, TRAP.
REQ-016 FETCH: mem_req=1, addr_src=0; on mem_ready: ir_write=1, pc_write=1 (PC+4), next DECODE.
REQ-017 DECODE by opcode: load/store -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111/0010111 -> LUI; else -> TRAP.
REQ-018 imm_src is combinational from instr in every state after FETCH: loads/JALR/I-ALU 000, except funct3 001/101 I-ALU 101; stores 001; branches 010; LUI/AUIPC 011; JAL 100.
REQ-019 MEMADR -> MEMREAD (load) or MEMWRITE (store); MEMREAD: mem_req=1, addr_src=1, on mem_ready -> MEMWB; MEMWRITE: mem_req=1, mem_we=1, on mem_ready -> FETCH.
REQ-020 MEMWB, ALUWB, JAL, JALR, LUI assert reg_write=1 for exactly one cycle then -> FETCH (EXECR/EXECI -> ALUWB).
REQ-021 BRANCH: pc_write=zero for BEQ and !zero for BNE, one cycle, -> FETCH; other funct3 -> TRAP.
REQ-022 JAL/JALR assert pc_write=1 and reg_write=1 (link PC+4) in the same cycle.
REQ-023 alu_ctrl generated from opcode/funct3/funct7[5]; SUB/SRA only when funct7[5]=1 in EXECR, SRAI when funct7[5]=1 in EXECI.
REQ-024 8-bit wait counter clears on entering any memory state and increments each cycle mem_req=1 without mem_ready; reaching TIMEOUT_CYCLES -> TRAP.
REQ-025 mem_ready arriving on the same cycle the counter reaches TIMEOUT_CYCLES counts as success.
REQ-026 mem_ready while mem_req=0 is ignored.
REQ-027 TRAP: trap=1, all enables and mem_req 0, remain until reset.
REQ-028 At most one of pc_write-from-branch, reg_write, mem_we active per cycle except JAL/JALR per REQ-022.

Reset
REQ-029 rst asserted: state=FETCH, counter=0, trap=0, all enables/mem_req/mem_we=0, all selects=0, immediately and asynchronously.
REQ-030 rst mid-access abandons the request; first cycle after release is FETCH with mem_req=1.

Structure
REQ-031 ctrl_pkg holds the state enum, opcode constants, imm_src encodings, and alu_ctrl encodings.
REQ-032 One sub-module, alu_decoder, combinationally maps opcode/funct3/funct7[5] to alu_ctrl.

Verification
REQ-033 ADDI x1,x0,5 (0x00500093), mem_ready after 1 cycle -> states FETCH,DECODE,EXECI,ALUWB; imm_src=000; reg_write one cycle.
REQ-034 SW (0x00112223) -> MEMADR, MEMWRITE with mem_we=1, imm_src=001; no reg_write.
REQ-035 BEQ with zero=1 then zero=0 -> pc_write=1 and 0 respectively in BRANCH; imm_src=010.
REQ-036 mem_ready withheld, TIMEOUT_CYCLES=4 -> TRAP after 4 waiting cycles; trap stays 1 until rst.
REQ-037 Opcode 0000000 -> TRAP from DECODE; rst during MEMREAD -> FETCH, mem_req=1 next cycle.
